trace_collector: RTL and testbench
==================================

Name: trace_collector

Overview:
- Next-generation commit tracer. Captures per-warp commit records with a parametrised number of register-write ports.
- Buffers records in an internal FIFO so the commit path never stalls.
- Serialises each record into one event per enabled register write on a valid/ready stream, consumed by the simulation-side trace sink.
- Adds a runtime warp filter, sequence numbering and drop accounting.

Parameters:
ARCH_LEN, 32, data/PC width per lane
NUM_WARPS, 8, warps per core; WARP_ID_BITS = $clog2(NUM_WARPS)
NUM_LANES, 16, lanes per warp
REG_BITS, 8, register address width
NUM_REG_PORTS, 3, register-write ports per record (>=1)
DEPTH, 8, FIFO depth in records (power of 2, >=2)
SEQ_BITS, 32, sequence number width
CNT_BITS, 16, drop counter width

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high
in_valid  in  1  commit record present
in_pc  in  ARCH_LEN  PC
in_warpId  in  WARP_ID_BITS  warp id
in_tmask  in  NUM_LANES  thread mask
in_regs_enable  in  NUM_REG_PORTS  per-port write enable
in_regs_address  in  NUM_REG_PORTS*REG_BITS  port i at [REG_BITS*i +: REG_BITS]
in_regs_data  in  NUM_REG_PORTS*NUM_LANES*ARCH_LEN  port i lane l at [(i*NUM_LANES+l)*ARCH_LEN +: ARCH_LEN]
warp_filter  in  NUM_WARPS  bit w=1 enables tracing of warp w
out_valid  out  1  event present
out_ready  in  1  sink accepts event
out_pc, out_warpId, out_tmask  out  as inputs  record fields
out_seq  out  SEQ_BITS  record sequence number
out_regEnable  out  1  0 = record had no enabled ports
out_regPort  out  $clog2(NUM_REG_PORTS) (min 1)  source port index
out_regAddress  out  REG_BITS  register address
out_regData  out  NUM_LANES*ARCH_LEN  lane data
out_last  out  1  final event of the record
drop_count  out  CNT_BITS  records dropped, saturating
overflow  out  1  sticky: at least one drop since reset

Behaviour:
- Reset: FIFO empty, out_valid=0, all out_* fields 0, seq counter 0, drop_count 0, overflow 0, drain FSM in IDLE. Reset mid-drain discards all buffered records and the partial record; no event is emitted in the reset cycle.
- Qualify: a record qualifies when in_valid && warp_filter[in_warpId]. Non-qualifying cycles change no state.
- Sequence: each qualifying record takes the current seq value; the counter increments by 1 (wraps at 2^SEQ_BITS) whether the record is accepted or dropped, so gaps in out_seq expose drops.
- Accept: accept when the FIFO is not full, or when it is full and the head's last event handshakes in the same cycle (pop-then-push).
- Drop: otherwise drop the record. drop_count increments, saturating at 2^CNT_BITS-1. overflow is set and held until reset.
- Latency: an accepted record into an empty FIFO at cycle N appears on out at N+1. No combinational path from in_* to out_*.
- Drain FSM, IDLE: FIFO empty, out_valid=0. On the FIFO going non-empty, load pending = head enables and go to EMIT.
- Drain FSM, EMIT: out_valid=1. Presented port = lowest set bit of pending; out_last=1 when exactly one bit is set. If pending==0 (no enables), emit one event with out_regEnable=0, out_regPort=0, out_regAddress=0, out_regData=0, out_last=1.
- EMIT handshake (out_valid && out_ready): clear the presented bit. If that was the last event, pop; then reload pending from the new head and stay in EMIT, or go to IDLE if empty.
- Out fields hold stable while out_valid && !out_ready.
- Port order within a record is ascending port index. Record order is FIFO order.
- Throughput: one event per cycle with out_ready held high; back-to-back records have no bubble.

Decomposition:
- trace_pkg: trace record struct (pc, warpId, tmask, seq, enables, addresses, data), WARP_ID_BITS and PORT_BITS localparams, drain FSM state enum.
- Sub-module trace_fifo: parametrised-depth record FIFO with full/empty flags and same-cycle push/pop when full. Serialiser, filter and counters stay in trace_collector.

Test Plan:
- Single record, warp 2, enables=3'b101, addresses 5/9, out_ready=1 -> two events on cycles N+1, N+2: port0 addr5 last=0, port2 addr9 last=1, seq=0.
- Record with enables=0 -> one event, out_regEnable=0, out_last=1; next record gets seq=1.
- warp_filter=8'b0000_0001, records on warps 0,1,0 -> only warp-0 records emitted, seq 0 and 1, drop_count=0.
- out_ready=0, 10 single-port records with DEPTH=8 -> 8 buffered, drop_count=2, overflow=1; releasing ready emits seq 0..7 in order.
- FIFO full with the head's last event handshaking while in_valid -> new record accepted, drop_count unchanged.
- Reset asserted mid-record (after 1 of 3 events) -> next cycle out_valid=0, drop_count=0; a following record emits with seq=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and sizing helpers for the commit trace collector.
package trace_pkg;

    // Width helpers: a field for N choices, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Field widths for the default core configuration (8 warps, 3 write ports).
    localparam int WARP_ID_BITS = idx_bits(8);
    localparam int PORT_BITS    = idx_bits(3);

    // Drain FSM: IDLE while the record buffer is empty, EMIT while events are offered.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } drain_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO: power-of-two depth, full/empty/single flags, and a push that
// is accepted while full when the head pops in the same cycle.
module trace_fifo
    import trace_pkg::*;
#(
    parameter type rec_t = logic,
    parameter int  DEPTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  rec_t push_data,
    input  logic pop,
    output rec_t head,
    output logic full,
    output logic empty,
    output logic single
);

    localparam int AW = $clog2(DEPTH);

    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign single  = (count == (AW+1)'(1));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Record storage; contents are only observed while the FIFO is non-empty.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/trace_collector.sv
// Commit tracer: filters commit records by warp, numbers them, buffers them
// and serialises each into one event per enabled register-write port.
module trace_collector
    import trace_pkg::*;
#(
    parameter int ARCH_LEN      = 32,
    parameter int NUM_WARPS     = 8,
    parameter int NUM_LANES     = 16,
    parameter int REG_BITS      = 8,
    parameter int NUM_REG_PORTS = 3,
    parameter int DEPTH         = 8,
    parameter int SEQ_BITS      = 32,
    parameter int CNT_BITS      = 16,
    localparam int WID_W        = idx_bits(NUM_WARPS),
    localparam int PORT_W       = idx_bits(NUM_REG_PORTS)
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    in_valid,
    input  logic [ARCH_LEN-1:0]                     in_pc,
    input  logic [WID_W-1:0]                        in_warpId,
    input  logic [NUM_LANES-1:0]                    in_tmask,
    input  logic [NUM_REG_PORTS-1:0]                in_regs_enable,
    input  logic [NUM_REG_PORTS*REG_BITS-1:0]       in_regs_address,
    input  logic [NUM_REG_PORTS*NUM_LANES*ARCH_LEN-1:0] in_regs_data,
    input  logic [NUM_WARPS-1:0]                    warp_filter,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [ARCH_LEN-1:0]                     out_pc,
    output logic [WID_W-1:0]                        out_warpId,
    output logic [NUM_LANES-1:0]                    out_tmask,
    output logic [SEQ_BITS-1:0]                     out_seq,
    output logic                                    out_regEnable,
    output logic [PORT_W-1:0]                       out_regPort,
    output logic [REG_BITS-1:0]                     out_regAddress,
    output logic [NUM_LANES*ARCH_LEN-1:0]           out_regData,
    output logic                                    out_last,
    output logic [CNT_BITS-1:0]                     drop_count,
    output logic                                    overflow
);

    localparam int NRP     = NUM_REG_PORTS;
    localparam int LANE_W  = NUM_LANES * ARCH_LEN;
    localparam int ADDR_IW = $clog2(NRP * REG_BITS);
    localparam int DATA_IW = $clog2(NRP * LANE_W);

    typedef struct packed {
        logic [ARCH_LEN-1:0]     pc;
        logic [WID_W-1:0]        warp_id;
        logic [NUM_LANES-1:0]    tmask;
        logic [SEQ_BITS-1:0]     seq;
        logic [NRP-1:0]          en;
        logic [NRP*REG_BITS-1:0] addr;
        logic [NRP*LANE_W-1:0]   data;
    } rec_t;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + CNT_BITS'(1);
    endfunction

    rec_t               in_rec;
    rec_t               head;
    drain_state_t       state;
    logic               qualify;
    logic               push;
    logic               pop;
    logic               handshake;
    logic               is_last;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_single;
    logic               found;
    logic [PORT_W-1:0]  sel;
    logic [NRP-1:0]     sent;
    logic [NRP-1:0]     pending;
    logic [SEQ_BITS-1:0] seq;
    logic [ADDR_IW-1:0] addr_lsb;
    logic [DATA_IW-1:0] data_lsb;

    assign qualify   = in_valid && warp_filter[in_warpId];
    assign handshake = out_valid && out_ready;
    assign pop       = handshake && is_last;
    assign push      = qualify && (!fifo_full || pop);

    assign in_rec = '{pc:      in_pc,
                      warp_id: in_warpId,
                      tmask:   in_tmask,
                      seq:     seq,
                      en:      in_regs_enable,
                      addr:    in_regs_address,
                      data:    in_regs_data};

    trace_fifo #(
        .rec_t (rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (in_rec),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .single    (fifo_single)
    );

    // Ports of the head record still to be emitted, and the lowest of them.
    assign pending = head.en & ~sent;
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NRP; i++) begin
            if (!found && pending[i]) begin
                found = 1'b1;
                sel   = PORT_W'(i);
            end
        end
    end

    // Zero or one pending bit means this event closes the record.
    assign is_last  = ((pending & (pending - NRP'(1))) == '0);
    assign addr_lsb = ADDR_IW'(sel * REG_BITS);
    assign data_lsb = DATA_IW'(sel * LANE_W);

    assign out_valid      = (state == EMIT);
    assign out_pc         = out_valid ? head.pc      : '0;
    assign out_warpId     = out_valid ? head.warp_id : '0;
    assign out_tmask      = out_valid ? head.tmask   : '0;
    assign out_seq        = out_valid ? head.seq     : '0;
    assign out_regEnable  = out_valid && found;
    assign out_regPort    = out_regEnable ? sel : '0;
    assign out_regAddress = out_regEnable ? head.addr[addr_lsb +: REG_BITS] : '0;
    assign out_regData    = out_regEnable ? head.data[data_lsb +: LANE_W] : '0;
    assign out_last       = out_valid && is_last;

    // Drain FSM, sequence numbering and drop accounting.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sent       <= '0;
            seq        <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (qualify) begin
                seq <= seq + SEQ_BITS'(1);
                if (!push) begin
                    drop_count <= sat_inc(drop_count);
                    overflow   <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (push) state <= EMIT;
                end
                EMIT: begin
                    if (handshake) begin
                        if (is_last) begin
                            sent <= '0;
                            if (fifo_single && !push) state <= IDLE;
                        end else begin
                            sent <= sent | (NRP'(1) << sel);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_collector.sv
// Directed bench for trace_collector: stimulus pushes expected events into a
// queue, a monitor compares every handshaked event against the queue head.
module tb_trace_collector;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [31:0]   in_pc;
    logic [2:0]    in_warpId;
    logic [15:0]   in_tmask;
    logic [2:0]    in_regs_enable;
    logic [23:0]   in_regs_address;
    logic [1535:0] in_regs_data;
    logic [7:0]    warp_filter;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [2:0]    out_warpId;
    logic [15:0]   out_tmask;
    logic [31:0]   out_seq;
    logic          out_regEnable;
    logic [1:0]    out_regPort;
    logic [7:0]    out_regAddress;
    logic [511:0]  out_regData;
    logic          out_last;
    logic [15:0]   drop_count;
    logic          overflow;

    always #5 clock = ~clock;

    trace_collector dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_pc           (in_pc),
        .in_warpId       (in_warpId),
        .in_tmask        (in_tmask),
        .in_regs_enable  (in_regs_enable),
        .in_regs_address (in_regs_address),
        .in_regs_data    (in_regs_data),
        .warp_filter     (warp_filter),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_warpId      (out_warpId),
        .out_tmask       (out_tmask),
        .out_seq         (out_seq),
        .out_regEnable   (out_regEnable),
        .out_regPort     (out_regPort),
        .out_regAddress  (out_regAddress),
        .out_regData     (out_regData),
        .out_last        (out_last),
        .drop_count      (drop_count),
        .overflow        (overflow)
    );

    typedef struct {
        logic [31:0]  pc;
        logic [2:0]   warp;
        logic [15:0]  tmask;
        logic [31:0]  seq;
        logic         en;
        logic [1:0]   port;
        logic [7:0]   addr;
        logic [511:0] data;
        logic         last;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Drive one record for one cycle; called just after a rising edge.
    task automatic send(input logic [31:0] pc, input logic [2:0] warp, input logic [15:0] tmask,
                        input logic [2:0] en, input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] a2, input logic [31:0] seq, input bit accept);
        logic [1535:0] d;
        ev_t e;
        d = '0;
        for (int p = 0; p < 3; p++)
            for (int l = 0; l < 16; l++)
                d[(p*16+l)*32 +: 32] = {8'(p), 8'(l), pc[15:0]};
        in_pc           = pc;
        in_warpId       = warp;
        in_tmask        = tmask;
        in_regs_enable  = en;
        in_regs_address = {a2, a1, a0};
        in_regs_data    = d;
        in_valid        = 1'b1;
        if (accept) begin
            e.pc = pc; e.warp = warp; e.tmask = tmask; e.seq = seq;
            if (en == 3'b000) begin
                e.en = 1'b0; e.port = 2'd0; e.addr = 8'd0; e.data = '0; e.last = 1'b1;
                exp_q.push_back(e);
            end else begin
                for (int p = 0; p < 3; p++) begin
                    if (en[p]) begin
                        e.en   = 1'b1;
                        e.port = 2'(p);
                        e.addr = (p == 0) ? a0 : (p == 1) ? a1 : a2;
                        e.data = d[p*512 +: 512];
                        e.last = ((en >> (p + 1)) == 3'b000);
                        exp_q.push_back(e);
                    end
                end
            end
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(posedge clock); #1;
        end
        check(name, {63'd0, (exp_q.size() == 0 && !out_valid)}, 64'd1);
    endtask

    // Monitor: every accepted event must match the oldest expected event.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got seq=%0d port=%0d addr=%0h, required no event",
                         out_seq, out_regPort, out_regAddress);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_pc !== mon_e.pc || out_warpId !== mon_e.warp || out_tmask !== mon_e.tmask ||
                    out_seq !== mon_e.seq || out_regEnable !== mon_e.en || out_regPort !== mon_e.port ||
                    out_regAddress !== mon_e.addr || out_regData !== mon_e.data || out_last !== mon_e.last) begin
                    fails++;
                    $display("FAIL event: got pc=%0h w=%0d tm=%0h seq=%0d en=%0b port=%0d addr=%0h last=%0b data_ok=%0b, required pc=%0h w=%0d tm=%0h seq=%0d en=%0b port=%0d addr=%0h last=%0b",
                             out_pc, out_warpId, out_tmask, out_seq, out_regEnable, out_regPort,
                             out_regAddress, out_last, (out_regData === mon_e.data),
                             mon_e.pc, mon_e.warp, mon_e.tmask, mon_e.seq, mon_e.en, mon_e.port,
                             mon_e.addr, mon_e.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_warpId = '0; in_tmask = '0;
        in_regs_enable = '0; in_regs_address = '0; in_regs_data = '0;
        warp_filter = 8'hFF; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clock);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_last",  {63'd0, out_last}, 64'd0);
        check("rst_out_pc",    {32'd0, out_pc}, 64'd0);
        check("rst_out_seq",   {32'd0, out_seq}, 64'd0);
        check("rst_drop",      {48'd0, drop_count}, 64'd0);
        check("rst_overflow",  {63'd0, overflow}, 64'd0);
        @(posedge clock); #1;

        // Two-port record, one cycle latency.
        send(32'h0000_0100, 3'd2, 16'hFFFF, 3'b101, 8'd5, 8'd7, 8'd9, 32'd0, 1'b1);
        @(negedge clock);
        check("t1_latency_valid", {63'd0, out_valid}, 64'd1);
        check("t1_latency_addr",  {56'd0, out_regAddress}, 64'd5);
        @(posedge clock); #1;
        wait_drain("t1_drain");

        // Record without enabled ports, next sequence number.
        send(32'h0000_0200, 3'd3, 16'h00FF, 3'b000, 8'd1, 8'd2, 8'd3, 32'd1, 1'b1);
        wait_drain("t2_drain");

        // Warp filter.
        do_reset();
        warp_filter = 8'b0000_0001;
        send(32'h0000_0300, 3'd0, 16'h0001, 3'b001, 8'h21, 8'h00, 8'h00, 32'd0, 1'b1);
        send(32'h0000_0304, 3'd1, 16'h0002, 3'b001, 8'h22, 8'h00, 8'h00, 32'd0, 1'b0);
        send(32'h0000_0308, 3'd0, 16'h0004, 3'b001, 8'h23, 8'h00, 8'h00, 32'd1, 1'b1);
        wait_drain("t3_drain");
        check("t3_drop",     {48'd0, drop_count}, 64'd0);
        check("t3_overflow", {63'd0, overflow}, 64'd0);

        // Overflow with the sink stalled.
        do_reset();
        warp_filter = 8'hFF;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            send(32'h0000_0400 + 32'(4*i), 3'(i), 16'h0F0F, 3'b001, 8'(10+i), 8'h00, 8'h00,
                 32'(i), (i < 8));
        check("t4_drop",     {48'd0, drop_count}, 64'd2);
        check("t4_overflow", {63'd0, overflow}, 64'd1);
        check("t4_valid",    {63'd0, out_valid}, 64'd1);
        check("t4_seq_head", {32'd0, out_seq}, 64'd0);
        repeat (2) begin @(posedge clock); #1; end
        check("t4_hold_seq",  {32'd0, out_seq}, 64'd0);
        check("t4_hold_addr", {56'd0, out_regAddress}, 64'd10);
        out_ready = 1'b1;
        repeat (8) begin @(posedge clock); #1; end
        check("t4_no_bubble_valid", {63'd0, out_valid}, 64'd0);
        check("t4_no_bubble_queue", 64'(exp_q.size()), 64'd0);
        check("t4_overflow_held",   {63'd0, overflow}, 64'd1);
        wait_drain("t4_drain");

        // Full FIFO, head pops in the same cycle as a new push.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            send(32'h0000_0500 + 32'(4*i), 3'd4, 16'h1234, 3'b001, 8'(32+i), 8'h00, 8'h00,
                 32'(i), 1'b1);
        check("t5_drop_full", {48'd0, drop_count}, 64'd0);
        out_ready = 1'b1;
        send(32'h0000_0520, 3'd6, 16'h5678, 3'b010, 8'h00, 8'h77, 8'h00, 32'd8, 1'b1);
        check("t5_drop_after", {48'd0, drop_count}, 64'd0);
        check("t5_overflow",   {63'd0, overflow}, 64'd0);
        wait_drain("t5_drain");

        // Reset in the middle of a three-event record.
        do_reset();
        out_ready = 1'b1;
        send(32'h0000_0600, 3'd5, 16'hAAAA, 3'b111, 8'h61, 8'h62, 8'h63, 32'd0, 1'b1);
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("t6_remaining", 64'(exp_q.size()), 64'd2);
        do_reset();
        check("t6_valid", {63'd0, out_valid}, 64'd0);
        check("t6_drop",  {48'd0, drop_count}, 64'd0);
        out_ready = 1'b1;
        send(32'h0000_0700, 3'd1, 16'h0001, 3'b010, 8'h00, 8'h42, 8'h00, 32'd0, 1'b1);
        wait_drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
